// File: rtl/cia6526_pkg.sv
// cia6526_pkg
//   Shared constants for the 6526 CIA model: register offsets, control
//   register bit positions, ICR bit positions, timer B count-source
//   encoding and the port read helper.
package cia6526_pkg;

    localparam logic [3:0] REG_PRA   = 4'h0;
    localparam logic [3:0] REG_PRB   = 4'h1;
    localparam logic [3:0] REG_DDRA  = 4'h2;
    localparam logic [3:0] REG_DDRB  = 4'h3;
    localparam logic [3:0] REG_TA_LO = 4'h4;
    localparam logic [3:0] REG_TA_HI = 4'h5;
    localparam logic [3:0] REG_TB_LO = 4'h6;
    localparam logic [3:0] REG_TB_HI = 4'h7;
    localparam logic [3:0] REG_ICR   = 4'hD;
    localparam logic [3:0] REG_CRA   = 4'hE;
    localparam logic [3:0] REG_CRB   = 4'hF;

    localparam int CR_START   = 0;
    localparam int CR_RUNMODE = 3;
    localparam int CR_LOAD    = 4;
    localparam int CR_INMODE  = 5;

    localparam int ICR_TA  = 0;
    localparam int ICR_TB  = 1;
    localparam int ICR_FLG = 4;
    localparam int ICR_SET = 7;

    typedef enum logic [1:0] {
        TB_SRC_PHI2   = 2'b00,
        TB_SRC_CNT    = 2'b01,
        TB_SRC_TA     = 2'b10,
        TB_SRC_TA_CNT = 2'b11
    } tb_src_e;

    // Output bits show the register, input bits show the pin.
    function automatic logic [7:0] port_read(input logic [7:0] pr,
                                             input logic [7:0] ddr,
                                             input logic [7:0] pins);
        return (pr & ddr) | (pins & ~ddr);
    endfunction

endpackage

// File: rtl/cia_timer.sv
// cia_timer
//   One 16-bit CIA interval timer: latch, counter, control register and
//   reload/underflow logic.
//   Ports: clk/reset, i_count_en (count source qualifier), i_wr_lo/i_wr_hi/
//   i_wr_cr (already gated write strobes), i_data (write data),
//   o_count (live counter), o_cr (control register readback),
//   o_underflow (high in the cycle whose edge underflows).
module cia_timer
    import cia6526_pkg::*;
#(
    parameter logic [15:0] LATCH_RESET = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_count_en,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic        i_wr_cr,
    input  logic [7:0]  i_data,
    output logic [15:0] o_count,
    output logic [7:0]  o_cr,
    output logic        o_underflow
);

    logic [15:0] r_latch;
    logic [15:0] r_count;
    logic [7:0]  r_cr;
    logic        w_force;
    logic        w_counting;
    logic [7:0]  w_cr_next;

    assign w_force    = i_wr_cr & i_data[CR_LOAD];
    assign w_counting = r_cr[CR_START] & i_count_en;
    // A force load on the same edge reloads anyway, so no underflow is reported.
    assign o_underflow = w_counting & (r_count == 16'h0000) & ~w_force;
    assign o_count     = r_count;
    assign o_cr        = r_cr;

    // FORCE LOAD is a strobe and is never stored.
    always_comb begin
        w_cr_next          = i_data;
        w_cr_next[CR_LOAD] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_latch <= LATCH_RESET;
            r_count <= 16'h0000;
            r_cr    <= 8'h00;
        end else begin
            if (i_wr_lo) r_latch[7:0]  <= i_data;
            if (i_wr_hi) r_latch[15:8] <= i_data;

            if (w_force)
                r_count <= r_latch;
            else if (i_wr_hi && !r_cr[CR_START])
                r_count <= {i_data, r_latch[7:0]};
            else if (w_counting)
                r_count <= (r_count == 16'h0000) ? r_latch : r_count - 16'd1;

            if (i_wr_cr)
                r_cr <= w_cr_next;
            else if (o_underflow && r_cr[CR_RUNMODE])
                r_cr[CR_START] <= 1'b0;
        end
    end

endmodule

// File: rtl/cia6526.sv
// cia6526
//   Cycle-based MOS 6526 CIA: two I/O ports, timers A/B, interrupt control.
//   Ports: clk/reset (sync, active high), bus_en/cs/addr/we/data_i (CPU bus,
//   side effects only when cs & bus_en), data_o (combinational read data),
//   irq (active-high, registered), pa_i/pb_i and pa_o/pb_o (port pins,
//   undriven bits pulled up), flag_n (falling-edge interrupt input).
module cia6526
    import cia6526_pkg::*;
#(
    parameter logic [15:0] LATCH_RESET = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bus_en,
    input  logic       cs,
    input  logic [3:0] addr,
    input  logic       we,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       irq,
    input  logic [7:0] pa_i,
    input  logic [7:0] pb_i,
    output logic [7:0] pa_o,
    output logic [7:0] pb_o,
    input  logic       flag_n
);

    logic [7:0]  r_pra, r_prb, r_ddra, r_ddrb;
    logic [4:0]  r_mask;
    logic [4:0]  r_flags;
    logic        r_irq;
    logic        r_flag_q;

    logic        w_wr, w_rd, w_icr_rd, w_flag_fall;
    logic        w_ta_cnt_en, w_tb_cnt_en, w_ta_uf, w_tb_uf;
    logic [15:0] w_ta_count, w_tb_count;
    logic [7:0]  w_cra, w_crb;
    logic [4:0]  w_flag_set;

    assign w_wr        = cs & bus_en & we;
    assign w_rd        = cs & bus_en & ~we;
    assign w_icr_rd    = w_rd & (addr == REG_ICR);
    assign w_flag_fall = r_flag_q & ~flag_n;

    assign w_ta_cnt_en = ~w_cra[CR_INMODE];

    always_comb begin
        w_tb_cnt_en = 1'b0;
        case (tb_src_e'(w_crb[CR_INMODE+1:CR_INMODE]))
            TB_SRC_PHI2: w_tb_cnt_en = 1'b1;
            TB_SRC_TA:   w_tb_cnt_en = w_ta_uf;
            default:     w_tb_cnt_en = 1'b0;
        endcase
    end

    cia_timer #(.LATCH_RESET(LATCH_RESET)) u_ta (
        .clk        (clk),
        .reset      (reset),
        .i_count_en (w_ta_cnt_en),
        .i_wr_lo    (w_wr && addr == REG_TA_LO),
        .i_wr_hi    (w_wr && addr == REG_TA_HI),
        .i_wr_cr    (w_wr && addr == REG_CRA),
        .i_data     (data_i),
        .o_count    (w_ta_count),
        .o_cr       (w_cra),
        .o_underflow(w_ta_uf)
    );

    cia_timer #(.LATCH_RESET(LATCH_RESET)) u_tb (
        .clk        (clk),
        .reset      (reset),
        .i_count_en (w_tb_cnt_en),
        .i_wr_lo    (w_wr && addr == REG_TB_LO),
        .i_wr_hi    (w_wr && addr == REG_TB_HI),
        .i_wr_cr    (w_wr && addr == REG_CRB),
        .i_data     (data_i),
        .o_count    (w_tb_count),
        .o_cr       (w_crb),
        .o_underflow(w_tb_uf)
    );

    always_comb begin
        w_flag_set          = 5'b00000;
        w_flag_set[ICR_TA]  = w_ta_uf;
        w_flag_set[ICR_TB]  = w_tb_uf;
        w_flag_set[ICR_FLG] = w_flag_fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pra    <= 8'h00;
            r_prb    <= 8'h00;
            r_ddra   <= 8'h00;
            r_ddrb   <= 8'h00;
            r_mask   <= 5'b00000;
            r_flags  <= 5'b00000;
            r_irq    <= 1'b0;
            r_flag_q <= 1'b1;
        end else begin
            r_flag_q <= flag_n;
            if (w_wr) begin
                case (addr)
                    REG_PRA:  r_pra  <= data_i;
                    REG_PRB:  r_prb  <= data_i;
                    REG_DDRA: r_ddra <= data_i;
                    REG_DDRB: r_ddrb <= data_i;
                    REG_ICR:  r_mask <= data_i[ICR_SET] ? (r_mask | data_i[4:0])
                                                        : (r_mask & ~data_i[4:0]);
                    default:  ;
                endcase
            end
            // New flags from this edge survive a read-clear on the same edge.
            r_flags <= (w_icr_rd ? 5'b00000 : r_flags) | w_flag_set;
            r_irq   <= w_icr_rd ? 1'b0 : (r_irq | (|(r_flags & r_mask)));
        end
    end

    always_comb begin
        data_o = 8'h00;
        case (addr)
            REG_PRA:   data_o = port_read(r_pra, r_ddra, pa_i);
            REG_PRB:   data_o = port_read(r_prb, r_ddrb, pb_i);
            REG_DDRA:  data_o = r_ddra;
            REG_DDRB:  data_o = r_ddrb;
            REG_TA_LO: data_o = w_ta_count[7:0];
            REG_TA_HI: data_o = w_ta_count[15:8];
            REG_TB_LO: data_o = w_tb_count[7:0];
            REG_TB_HI: data_o = w_tb_count[15:8];
            REG_ICR:   data_o = {r_irq, 2'b00, r_flags};
            REG_CRA:   data_o = w_cra;
            REG_CRB:   data_o = w_crb;
            default:   data_o = 8'h00;
        endcase
    end

    assign pa_o = r_pra | ~r_ddra;
    assign pb_o = r_prb | ~r_ddrb;
    assign irq  = r_irq;

endmodule

// File: tb/tb_cia6526.sv
// tb_cia6526
//   Directed bench for cia6526: reset state, one-shot and continuous timer A,
//   timer cascade, ports, ICR read/underflow race, gated FLAG access,
//   reset mid-count and force load.
module tb_cia6526;

    logic       clk = 1'b0;
    logic       reset, bus_en, cs, we, flag_n;
    logic [3:0] addr;
    logic [7:0] data_i, data_o, pa_i, pb_i, pa_o, pb_o;
    logic       irq;
    logic [7:0] rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cia6526 dut (
        .clk   (clk),
        .reset (reset),
        .bus_en(bus_en),
        .cs    (cs),
        .addr  (addr),
        .we    (we),
        .data_i(data_i),
        .data_o(data_o),
        .irq   (irq),
        .pa_i  (pa_i),
        .pb_i  (pb_i),
        .pa_o  (pa_o),
        .pb_o  (pb_o),
        .flag_n(flag_n)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        addr = a; data_i = d; we = 1'b1; cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        addr = a; we = 1'b0; cs = 1'b1;
        #1 d = data_o;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    // Side-effect free look at a register (chip not selected).
    task automatic peek_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        addr = a; cs = 1'b0;
        #1 check_val(tag, data_o, exp);
    endtask

    initial begin
        reset = 1'b1; bus_en = 1'b1; cs = 1'b0; we = 1'b0; addr = 4'h0;
        data_i = 8'h00; pa_i = 8'h3C; pb_i = 8'hC3; flag_n = 1'b1;
        step(2);
        reset = 1'b0;

        // reset state
        check_val("rst_irq", irq, 1'b0);
        check_val("rst_pa_o", pa_o, 8'hFF);
        check_val("rst_pb_o", pb_o, 8'hFF);
        peek_chk("rst_pra", 4'h0, 8'h3C);
        peek_chk("rst_cra", 4'hE, 8'h00);
        peek_chk("rst_ta_lo", 4'h4, 8'h00);
        peek_chk("rst_icr", 4'hD, 8'h00);

        // TA one-shot, latch 3
        bus_wr(4'h4, 8'h03);
        bus_wr(4'h5, 8'h00);
        peek_chk("os_hi_load", 4'h4, 8'h03);
        bus_wr(4'hE, 8'h09);
        step(3);
        peek_chk("os_cnt0", 4'h4, 8'h00);
        peek_chk("os_noflag", 4'hD, 8'h00);
        step(1);
        peek_chk("os_flag", 4'hD, 8'h01);
        peek_chk("os_cra", 4'hE, 8'h08);
        peek_chk("os_reload", 4'h4, 8'h03);
        step(2);
        peek_chk("os_hold", 4'h4, 8'h03);
        check_val("os_irq", irq, 1'b0);
        bus_rd(4'hD, rd);
        check_val("os_icr_rd", rd, 8'h01);
        peek_chk("os_icr_clr", 4'hD, 8'h00);

        // TA continuous, latch 2, mask TA
        bus_wr(4'hD, 8'h81);
        bus_wr(4'h4, 8'h02);
        bus_wr(4'h5, 8'h00);
        bus_wr(4'hE, 8'h01);
        step(3);
        peek_chk("ct_flag", 4'hD, 8'h01);
        check_val("ct_irq_lag", irq, 1'b0);
        step(1);
        check_val("ct_irq_rise", irq, 1'b1);
        bus_rd(4'hD, rd);
        check_val("ct_icr_rd", rd, 8'h81);
        check_val("ct_irq_drop", irq, 1'b0);
        step(1);
        check_val("ct_irq_lag2", irq, 1'b0);
        peek_chk("ct_flag2", 4'hD, 8'h01);
        step(1);
        check_val("ct_irq_rise2", irq, 1'b1);
        bus_wr(4'hE, 8'h00);
        bus_rd(4'hD, rd);
        check_val("ct_icr_rd2", rd, 8'h81);
        bus_wr(4'hD, 8'h01);
        check_val("ct_irq_off", irq, 1'b0);

        // cascade: TA latch 1, TB latch 2 counting TA underflows
        bus_wr(4'h4, 8'h01);
        bus_wr(4'h5, 8'h00);
        bus_wr(4'h6, 8'h02);
        bus_wr(4'h7, 8'h00);
        bus_wr(4'hF, 8'h41);
        bus_wr(4'hE, 8'h01);
        step(5);
        peek_chk("cs_flag_ta", 4'hD, 8'h01);
        peek_chk("cs_tb0", 4'h6, 8'h00);
        step(1);
        peek_chk("cs_flag_tb", 4'hD, 8'h03);
        peek_chk("cs_tb_reload", 4'h6, 8'h02);
        bus_rd(4'hD, rd);
        check_val("cs_icr_rd", rd, 8'h03);
        step(4);
        peek_chk("cs_flag_ta2", 4'hD, 8'h01);
        peek_chk("cs_tb0_2", 4'h6, 8'h00);
        step(1);
        peek_chk("cs_flag_tb2", 4'hD, 8'h03);
        peek_chk("cs_tb_reload2", 4'h6, 8'h02);
        bus_wr(4'hE, 8'h00);
        bus_wr(4'hF, 8'h00);
        bus_rd(4'hD, rd);
        check_val("cs_icr_rd2", rd, 8'h03);

        // race: TB underflow on the ICR read edge, mask TB
        bus_wr(4'hD, 8'h82);
        bus_wr(4'h6, 8'h02);
        bus_wr(4'h7, 8'h00);
        bus_wr(4'hF, 8'h01);
        step(2);
        peek_chk("rc_tb0", 4'h6, 8'h00);
        bus_rd(4'hD, rd);
        check_val("rc_old", rd, 8'h00);
        peek_chk("rc_flag_kept", 4'hD, 8'h02);
        check_val("rc_irq_lag", irq, 1'b0);
        step(1);
        check_val("rc_irq", irq, 1'b1);
        bus_wr(4'hF, 8'h00);
        bus_rd(4'hD, rd);
        check_val("rc_icr_rd", rd, 8'h82);
        check_val("rc_irq_clr", irq, 1'b0);
        bus_wr(4'hD, 8'h02);

        // FLAG fall, then gated ICR read and gated write
        flag_n = 1'b0;
        step(1);
        bus_en = 1'b0; cs = 1'b1; we = 1'b0; addr = 4'hD;
        step(1);
        cs = 1'b0;
        peek_chk("fl_flag", 4'hD, 8'h10);
        flag_n = 1'b1;
        cs = 1'b1; we = 1'b1; addr = 4'h2; data_i = 8'hFF;
        step(1);
        cs = 1'b0; we = 1'b0;
        peek_chk("fl_gated_wr", 4'h2, 8'h00);
        bus_en = 1'b1;
        bus_rd(4'hD, rd);
        check_val("fl_icr_rd", rd, 8'h10);
        check_val("fl_irq", irq, 1'b0);

        // ports
        pa_i = 8'hA0; pb_i = 8'h5A;
        bus_wr(4'h2, 8'h0F);
        bus_wr(4'h0, 8'h05);
        check_val("pt_pa_o", pa_o, 8'hF5);
        peek_chk("pt_pra", 4'h0, 8'hA5);
        bus_wr(4'h3, 8'hF0);
        bus_wr(4'h1, 8'h3C);
        check_val("pt_pb_o", pb_o, 8'h3F);
        peek_chk("pt_prb", 4'h1, 8'h3A);
        bus_wr(4'h9, 8'hFF);
        peek_chk("pt_unused", 4'h9, 8'h00);

        // reset mid-count, then force load from the reset latch
        bus_wr(4'h4, 8'h02);
        bus_wr(4'h5, 8'h00);
        bus_wr(4'hE, 8'h01);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_val("mr_pa_o", pa_o, 8'hFF);
        peek_chk("mr_cra", 4'hE, 8'h00);
        peek_chk("mr_ta_lo", 4'h4, 8'h00);
        peek_chk("mr_pra", 4'h0, 8'hA0);
        bus_wr(4'hE, 8'h10);
        peek_chk("fl_cra_rd0", 4'hE, 8'h00);
        peek_chk("fld_ta_lo", 4'h4, 8'hFF);
        peek_chk("fld_ta_hi", 4'h5, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
